// File: rtl/arm_pkg.sv
// Shared ARM pipeline definitions: default datapath widths, the NOP word and
// the prefetch queue entry layout.
package arm_pkg;

    localparam int ARM_ADDR_W  = 32;
    localparam int ARM_INSTR_W = 32;

    // Matches the instruction memory's default (unwritten) word.
    localparam logic [ARM_INSTR_W-1:0] INSTR_NOP = 32'h0000_0000;

    typedef struct packed {
        logic [ARM_ADDR_W-1:0]  pc;
        logic [ARM_INSTR_W-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Synchronous FIFO that holds prefetched instructions. It has a synchronous
// clear for redirects and exposes its occupancy.
module fetch_queue #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear_i,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [WIDTH-1:0]         wdata_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;

    // The caller guarantees push only when not full (or when popping) and
    // pop only when non-empty, so the count never needs to saturate.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_i) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop_i)  rd_ptr_d = rd_ptr_q + 1'b1;
            case ({push_i, pop_i})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && !clear_i && push_i) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/fetch_sequencer.sv
// IF-stage fetch controller. It owns the PC, fills the prefetch queue from
// the combinational instruction memory, and redirects fetch on taken branches.
module fetch_sequencer
    import arm_pkg::*;
#(
    parameter int                DEPTH    = 4,
    parameter int                ADDR_W   = ARM_ADDR_W,
    parameter int                INSTR_W  = ARM_INSTR_W,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     branch_taken,
    input  logic [ADDR_W-1:0]        branch_addr,
    output logic [ADDR_W-1:0]        imem_addr,
    input  logic [INSTR_W-1:0]       imem_instr,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [INSTR_W-1:0]       out_instr,
    output logic [ADDR_W-1:0]        out_pc,
    output logic [ADDR_W-1:0]        out_pc_plus4,
    output logic [$clog2(DEPTH):0]   q_count
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int EW = ADDR_W + INSTR_W;

    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic               pop, push;
    logic [EW-1:0]      head;
    logic [ADDR_W-1:0]  head_pc;
    logic [INSTR_W-1:0] head_instr;

    assign out_valid = (q_count != '0);
    assign pop       = out_valid & out_ready;
    // A full queue can still accept a word in the same cycle its head leaves.
    assign push      = ~branch_taken & ((q_count < CW'(DEPTH)) | pop);

    always_comb begin
        pc_d = pc_q;
        if (branch_taken) begin
            pc_d = branch_addr & ~ADDR_W'(3);
        end else if (push) begin
            pc_d = pc_q + ADDR_W'(4);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    fetch_queue #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_queue (
        .clk     (clk),
        .rst     (rst),
        .clear_i (branch_taken),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i ({pc_q, imem_instr}),
        .rdata_o (head),
        .count_o (q_count)
    );

    assign imem_addr  = pc_q;
    assign head_pc    = head[EW-1:INSTR_W];
    assign head_instr = head[INSTR_W-1:0];

    // Stale storage is masked so that an empty queue presents clean zeros.
    assign out_instr    = out_valid ? head_instr : INSTR_W'(INSTR_NOP);
    assign out_pc       = out_valid ? head_pc : '0;
    assign out_pc_plus4 = out_valid ? head_pc + ADDR_W'(4) : '0;

endmodule
